// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave register bank with programmable wait states and range-checked slave errors
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  Pclk,
    input  logic                  Presetn,
    input  logic                  Psel,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [ADDR_WIDTH-1:0] Paddr,
    input  logic [DATA_WIDTH-1:0] Pwdata,
    output logic [DATA_WIDTH-1:0] Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Transfer context captured in the setup phase; the master may change the bus afterwards.
    logic [IDX_W-1:0]      addr_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  setup;
    logic                  complete;
    logic                  enter_resp;
    logic                  addr_err;
    logic [IDX_W-1:0]      paddr_idx;
    logic                  cur_err;
    logic                  cur_write;
    logic [IDX_W-1:0]      cur_idx;

    // The full address is range-checked, so aliasing of high bits can never hit a real word.
    assign addr_err  = (Paddr >= ADDR_WIDTH'(DEPTH));
    assign paddr_idx = Paddr[IDX_W-1:0];

    // With zero wait states RESP is entered on the setup edge itself, before the context
    // registers hold the new transfer, so the response is built from the live bus then.
    assign cur_err   = setup ? addr_err  : err_q;
    assign cur_write = setup ? Pwrite    : write_q;
    assign cur_idx   = setup ? paddr_idx : addr_q;

    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

    // Next-state decode: setup detection, wait countdown, completion and abort.
    always_comb begin
        next_state = state;
        setup      = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Psel && !Penable) begin
                    setup      = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!Psel) begin
                    next_state = ST_IDLE;
                end else if (Penable && cnt == 4'd1) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!Psel) begin
                    next_state = ST_IDLE;
                end else if (Penable) begin
                    complete   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the transfer at setup and count down wait states during the access phase.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            cnt     <= 4'd0;
        end else if (setup) begin
            addr_q  <= paddr_idx;
            write_q <= Pwrite;
            err_q   <= addr_err;
            wdata_q <= Pwdata;
            cnt     <= 4'(WAIT_CYCLES);
        end else if (state == ST_WAIT && Psel && Penable && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Registered response: Pready/Pslverr track RESP, read data is loaded on entry to RESP.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            Prdata  <= '0;
        end else begin
            Pready  <= (next_state == ST_RESP);
            Pslverr <= (next_state == ST_RESP) && cur_err;
            if (enter_resp && !cur_write) begin
                Prdata <= cur_err ? '0 : mem[cur_idx];
            end
        end
    end

    // Word storage: writes commit only on a completing, in-range write.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete && write_q && !err_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem with zero and three wait states
module tb_apb_slave_mem;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        Pclk    = 1'b0;
    logic        Presetn = 1'b0;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model   [2][DEPTH];
    logic [31:0] last_rd [2];
    int          acc     [2];
    int          errors = 0;
    int          checks = 0;

    always #5 Pclk = ~Pclk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb_slave_mem #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (DEPTH),
            .WAIT_CYCLES(g == 0 ? 0 : 3)
        ) u_dut (
            .Pclk   (Pclk),
            .Presetn(Presetn),
            .Psel   (psel[g]),
            .Penable(penable[g]),
            .Pwrite (pwrite[g]),
            .Paddr  (paddr[g]),
            .Pwdata (pwdata[g]),
            .Prdata (prdata[g]),
            .Pready (pready[g]),
            .Pslverr(pslverr[g])
        );
    end

    function automatic int wc(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = '0;
            for (int i = 0; i < DEPTH; i++) model[k][i] = '0;
        end
    endtask

    // One APB transfer on instance k; an abort drops Psel in the first access cycle.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit abort);
        exp_t e;
        bit   err;
        bit   rdy;
        int   n;
        err = (addr >= DEPTH);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wd;
        if (!abort) begin
            e.err = err;
            e.lat = wc(k) + 1;
            if (wr) begin
                e.data = last_rd[k];
            end else begin
                e.data     = err ? 32'h0 : model[k][addr[5:0]];
                last_rd[k] = e.data;
            end
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge Pclk); #1;
        paddr[k]  = $urandom;
        pwdata[k] = $urandom;
        if (abort) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            @(posedge Pclk); #1;
            return;
        end
        penable[k] = 1'b1;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(negedge Pclk); rdy = pready[k];
            @(posedge Pclk); #1;
            n++;
        end
        check($sformatf("xfer_done[%0d]", k), 32'(rdy), 32'd1);
        if (rdy && wr && !err) model[k][addr[5:0]] = wd;
        psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Pclk);
        #1;
    endtask

    // Monitor: pops one expectation per Pready cycle and checks latency, error and data.
    initial begin
        exp_t e;
        bit   have;
        acc[0] = 0; acc[1] = 0;
        forever begin
            @(negedge Pclk);
            for (int k = 0; k < 2; k++) begin
                if (!Presetn) begin
                    acc[k] = 0;
                end else begin
                    if (psel[k] && !penable[k]) acc[k] = 0;
                    else if (psel[k] && penable[k]) acc[k]++;
                    if (pready[k]) begin
                        have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
                        if (!have) begin
                            check($sformatf("unexpected_pready[%0d]", k), 32'd1, 32'd0);
                        end else begin
                            if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                            check($sformatf("latency[%0d]", k), 32'(acc[k]), 32'(e.lat));
                            check($sformatf("pslverr[%0d]", k), 32'(pslverr[k]), 32'(e.err));
                            check($sformatf("prdata[%0d]", k), prdata[k], e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit          wr;
        bit          ab;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
        end
        clear_model();
        repeat (3) @(posedge Pclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_pready[%0d]", k), 32'(pready[k]), 32'd0);
            check($sformatf("rst_pslverr[%0d]", k), 32'(pslverr[k]), 32'd0);
            check($sformatf("rst_prdata[%0d]", k), prdata[k], 32'd0);
        end
        Presetn = 1'b1;
        idle(1);

        // Zero wait states: basic write/read, out-of-range, back-to-back.
        xfer(0, 1, 5, 32'hDEADBEEF, 0);
        xfer(0, 0, 5, 0, 0);
        idle(1);
        xfer(0, 1, 64, 32'h12345678, 0);
        xfer(0, 0, 63, 0, 0);
        xfer(0, 0, 64, 0, 0);
        xfer(0, 1, 10, 32'hA5A5A5A5, 0);
        xfer(0, 0, 10, 0, 0);

        // Three wait states: read after reset, abort, back-to-back.
        xfer(1, 0, 0, 0, 0);
        idle(1);
        xfer(1, 1, 3, 32'h11, 1);
        idle(2);
        xfer(1, 0, 3, 0, 0);
        xfer(1, 1, 10, 32'hA5A5A5A5, 0);
        xfer(1, 0, 10, 0, 0);

        // Randomized traffic on both instances.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 60; i++) begin
                wr = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 15));
                ab = (k == 1) && ($urandom_range(0, 9) == 0);
                xfer(k, wr, a, $urandom, ab);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
        end

        // Reset during the wait phase of a write.
        xfer(1, 1, 7, 32'h55, 0);
        xfer(1, 0, 7, 0, 0);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 7; pwdata[1] = 32'h77;
        @(posedge Pclk); #1;
        penable[1] = 1'b1;
        @(posedge Pclk); #1;
        Presetn = 1'b0;
        #1;
        check("midrst_prdata", prdata[1], 32'd0);
        check("midrst_pready", 32'(pready[1]), 32'd0);
        check("midrst_pslverr", 32'(pslverr[1]), 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0; pwrite[1] = 1'b0;
        clear_model();
        @(posedge Pclk); #1;
        Presetn = 1'b1;
        xfer(1, 0, 7, 0, 0);
        xfer(0, 0, 5, 0, 0);

        idle(3);
        check("sb_empty0", 32'(q0.size()), 32'd0);
        check("sb_empty1", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
